// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - decode inputs, memory handshake and datapath strobes of the multicycle sequencer
interface mc_sequencer_if #(
  parameter int CNTW = 32
);
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            zero;
  logic            mem_ready;
  logic            mem_req;
  logic            mem_we;
  logic            ir_we;
  logic            ab_we;
  logic            pc_we;
  logic [1:0]      pc_sel;
  logic            alu_src;
  logic [2:0]      alu_cmd;
  logic            reg_we;
  logic [1:0]      reg_dst;
  logic [1:0]      mem_to_reg;
  logic [2:0]      state;
  logic            illegal;
  logic            bus_err;
  logic [CNTW-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, ir_we, ab_we, pc_we, pc_sel, alu_src, alu_cmd,
           reg_we, reg_dst, mem_to_reg, state, illegal, bus_err, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, ir_we, ab_we, pc_we, pc_sel, alu_src, alu_cmd,
           reg_we, reg_dst, mem_to_reg, state, illegal, bus_err, retired
  );
endinterface

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout and retire counter
module mc_sequencer #(
  parameter int MEM_TIMEOUT     = 15,
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNTW            = 32
) (
  input  logic           clk,
  input  logic           reset,
  mc_sequencer_if.master bus
);
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  logic       mem_req, mem_we, ir_we, ab_we, pc_we, alu_src, reg_we;
  logic [1:0] pc_sel, reg_dst, mem_to_reg;
  logic [2:0] alu_cmd;

  logic op_r, r_add, r_sub, r_slt, r_jr, r_alu;
  logic op_addi, op_xori, op_lw, op_sw, op_beq, op_bne, op_j, op_jal, legal;

  assign op_r    = (bus.opcode == 6'h00);
  assign r_add   = op_r && (bus.funct == 6'h20);
  assign r_sub   = op_r && (bus.funct == 6'h22);
  assign r_slt   = op_r && (bus.funct == 6'h2A);
  assign r_jr    = op_r && (bus.funct == 6'h08);
  assign r_alu   = r_add || r_sub || r_slt;
  assign op_addi = (bus.opcode == 6'h08);
  assign op_xori = (bus.opcode == 6'h0E);
  assign op_lw   = (bus.opcode == 6'h23);
  assign op_sw   = (bus.opcode == 6'h2B);
  assign op_beq  = (bus.opcode == 6'h04);
  assign op_bne  = (bus.opcode == 6'h05);
  assign op_j    = (bus.opcode == 6'h02);
  assign op_jal  = (bus.opcode == 6'h03);
  assign legal   = r_alu || r_jr || op_addi || op_xori || op_lw || op_sw ||
                   op_beq || op_bne || op_j || op_jal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    alu_src    = 1'b0;
    alu_cmd    = 3'd0;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WLAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        if (op_j || op_jal) begin
          pc_we   = 1'b1;
          pc_sel  = 2'd2;
          state_d = S_FETCH;
          if (op_jal) begin
            reg_we     = 1'b1;
            reg_dst    = 2'd1;
            mem_to_reg = 2'd2;
          end
        end else if (r_jr) begin
          pc_we   = 1'b1;
          pc_sel  = 2'd3;
          state_d = S_FETCH;
        end else if (!legal) begin
          illegal_d = 1'b1;
          if (HALT_ON_ILLEGAL) begin
            state_d = S_HALT;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src = op_addi || op_xori || op_lw || op_sw;
        if (op_xori)                 alu_cmd = 3'd2;
        else if (op_beq || op_bne)   alu_cmd = 3'd1;
        else if (r_sub)              alu_cmd = 3'd1;
        else if (r_slt)              alu_cmd = 3'd3;
        if (op_beq || op_bne) begin
          pc_we   = 1'b1;
          pc_sel  = ((op_beq && bus.zero) || (op_bne && !bus.zero)) ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (op_lw || op_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Address stays on the ALU (base + offset) for the whole access.
        mem_req = 1'b1;
        mem_we  = op_sw;
        alu_src = 1'b1;
        if (bus.mem_ready) begin
          if (op_sw) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WLAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = op_r ? 2'd0 : 2'd2;
        mem_to_reg = op_lw ? 2'd1 : 2'd0;
        pc_we      = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset kills strobes immediately so a partial access never commits.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      ab_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'd0;
      alu_src    = 1'b0;
      alu_cmd    = 3'd0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
    end
  end

  assign retired_d = retired_q + CNTW'(pc_we);

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.ir_we      = ir_we;
  assign bus.ab_we      = ab_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.alu_src    = alu_src;
  assign bus.alu_cmd    = alu_cmd;
  assign bus.reg_we     = reg_we;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.retired    = retired_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - vector table, random program against an instruction-level model, corner sequences
module tb_mc_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_sequencer_if #(.CNTW(32)) ifa ();
  mc_sequencer_if #(.CNTW(32)) ifb ();

  assign ifb.opcode    = ifa.opcode;
  assign ifb.funct     = ifa.funct;
  assign ifb.zero      = ifa.zero;
  assign ifb.mem_ready = ifa.mem_ready;

  mc_sequencer #(.MEM_TIMEOUT(15), .HALT_ON_ILLEGAL(1'b1), .CNTW(32)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  mc_sequencer #(.MEM_TIMEOUT(15), .HALT_ON_ILLEGAL(1'b0), .CNTW(32)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    int done; int cycles; int sel; int reg_we; int dst; int m2r;
    int alu; int asrc; int mem_we; int mreq; int ir_we;
  } rec_t;

  typedef struct {
    int k; bit z; int fd; int md; rec_t e;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int exp_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Kinds: 0 add,1 sub,2 slt,3 jr,4 addi,5 xori,6 lw,7 sw,8 beq,9 bne,10 j,11 jal
  task automatic enc(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom_range(0, 63));
    case (k)
      0:  begin op = 6'h00; fn = 6'h20; end
      1:  begin op = 6'h00; fn = 6'h22; end
      2:  begin op = 6'h00; fn = 6'h2A; end
      3:  begin op = 6'h00; fn = 6'h08; end
      4:  op = 6'h08;
      5:  op = 6'h0E;
      6:  op = 6'h23;
      7:  op = 6'h2B;
      8:  op = 6'h04;
      9:  op = 6'h05;
      10: op = 6'h02;
      default: op = 6'h03;
    endcase
  endtask

  function automatic rec_t model(input int k, input bit z, input int fd, input int md);
    rec_t e;
    e = '{done: 1, cycles: 0, sel: 0, reg_we: 0, dst: 0, m2r: 0,
          alu: -1, asrc: 0, mem_we: 0, mreq: 0, ir_we: 1};
    case (k)
      0, 1, 2: begin e.cycles = 4; e.reg_we = 1; e.alu = (k == 0) ? 0 : (k == 1) ? 1 : 3; end
      3:  begin e.cycles = 2; e.sel = 3; end
      4:  begin e.cycles = 4; e.reg_we = 1; e.dst = 2; e.alu = 0; e.asrc = 1; end
      5:  begin e.cycles = 4; e.reg_we = 1; e.dst = 2; e.alu = 2; e.asrc = 1; end
      6:  begin e.cycles = 5 + md; e.reg_we = 1; e.dst = 2; e.m2r = 1; e.alu = 0; e.asrc = 1; e.mreq = md + 1; end
      7:  begin e.cycles = 4 + md; e.alu = 0; e.asrc = 1; e.mem_we = md + 1; e.mreq = md + 1; end
      8:  begin e.cycles = 3; e.sel = z ? 1 : 0; e.alu = 1; end
      9:  begin e.cycles = 3; e.sel = z ? 0 : 1; e.alu = 1; end
      10: begin e.cycles = 2; e.sel = 2; end
      default: begin e.cycles = 2; e.sel = 2; e.reg_we = 1; e.dst = 1; e.m2r = 2; end
    endcase
    e.cycles += fd;
    e.mreq   += fd + 1;
    return e;
  endfunction

  // Answers each memory request after 'fd' (fetch) or 'md' (data) idle cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fd, input int md, output rec_t o);
    int ph, cnt;
    bit prev_ab;
    o = '{done: 0, cycles: 0, sel: 0, reg_we: 0, dst: 0, m2r: 0,
          alu: -1, asrc: 0, mem_we: 0, mreq: 0, ir_we: 0};
    ph = 0; cnt = 0; prev_ab = 0;
    for (int c = 0; c < 60 && o.done == 0; c++) begin
      @(negedge clk);
      ifa.opcode = op; ifa.funct = fn; ifa.zero = z; ifa.mem_ready = 1'b0;
      #1;
      if (ifa.mem_req) ifa.mem_ready = (cnt == ((ph == 0) ? fd : md));
      #1;
      o.cycles++;
      if (ifa.mem_req) begin
        o.mreq++;
        if (ifa.mem_ready) begin cnt = 0; ph++; end else cnt++;
      end
      if (ifa.mem_we) o.mem_we++;
      if (ifa.ir_we)  o.ir_we++;
      if (prev_ab) begin o.alu = int'(ifa.alu_cmd); o.asrc = int'(ifa.alu_src); end
      prev_ab = ifa.ab_we;
      if (ifa.reg_we) begin o.reg_we++; o.dst = int'(ifa.reg_dst); o.m2r = int'(ifa.mem_to_reg); end
      if (ifa.pc_we) begin o.sel = int'(ifa.pc_sel); o.done = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_instr(input string nm, input int k, input bit z, input int fd,
                             input int md, input rec_t e);
    logic [5:0] op, fn;
    rec_t o;
    enc(k, op, fn);
    run_instr(op, fn, z, fd, md, o);
    exp_ret++;
    chk({nm, ".done"}, o.done, e.done);
    chk({nm, ".cycles"}, o.cycles, e.cycles);
    chk({nm, ".pc_sel"}, o.sel, e.sel);
    chk({nm, ".reg_we"}, o.reg_we, e.reg_we);
    if (e.reg_we != 0) begin
      chk({nm, ".reg_dst"}, o.dst, e.dst);
      chk({nm, ".mem_to_reg"}, o.m2r, e.m2r);
    end
    if (e.alu >= 0) begin
      chk({nm, ".alu_cmd"}, o.alu, e.alu);
      chk({nm, ".alu_src"}, o.asrc, e.asrc);
    end
    chk({nm, ".mem_we"}, o.mem_we, e.mem_we);
    chk({nm, ".mem_req"}, o.mreq, e.mreq);
    chk({nm, ".ir_we"}, o.ir_we, e.ir_we);
    chk({nm, ".retired"}, ifa.retired, exp_ret);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    ifa.mem_ready = 1'b0; ifa.opcode = 6'h00; ifa.funct = 6'h00; ifa.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_ret = 0;
  endtask

  vec_t vec[14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{0,  1'b0, 0, 0, '{1, 4, 0, 1, 0, 0,  0, 0, 0, 1, 1}};
    vec[1]  = '{1,  1'b0, 1, 0, '{1, 5, 0, 1, 0, 0,  1, 0, 0, 2, 1}};
    vec[2]  = '{2,  1'b0, 0, 0, '{1, 4, 0, 1, 0, 0,  3, 0, 0, 1, 1}};
    vec[3]  = '{3,  1'b0, 2, 0, '{1, 4, 3, 0, 0, 0, -1, 0, 0, 3, 1}};
    vec[4]  = '{4,  1'b0, 0, 0, '{1, 4, 0, 1, 2, 0,  0, 1, 0, 1, 1}};
    vec[5]  = '{5,  1'b0, 0, 0, '{1, 4, 0, 1, 2, 0,  2, 1, 0, 1, 1}};
    vec[6]  = '{6,  1'b0, 0, 3, '{1, 8, 0, 1, 2, 1,  0, 1, 0, 5, 1}};
    vec[7]  = '{7,  1'b0, 0, 1, '{1, 5, 0, 0, 0, 0,  0, 1, 2, 3, 1}};
    vec[8]  = '{8,  1'b1, 0, 0, '{1, 3, 1, 0, 0, 0,  1, 0, 0, 1, 1}};
    vec[9]  = '{8,  1'b0, 0, 0, '{1, 3, 0, 0, 0, 0,  1, 0, 0, 1, 1}};
    vec[10] = '{9,  1'b1, 0, 0, '{1, 3, 0, 0, 0, 0,  1, 0, 0, 1, 1}};
    vec[11] = '{9,  1'b0, 0, 0, '{1, 3, 1, 0, 0, 0,  1, 0, 0, 1, 1}};
    vec[12] = '{10, 1'b0, 0, 0, '{1, 2, 2, 0, 0, 0, -1, 0, 0, 1, 1}};
    vec[13] = '{11, 1'b0, 0, 0, '{1, 2, 2, 1, 1, 2, -1, 0, 0, 1, 1}};

    // Reset state, strobes held off while reset is high
    reset = 1'b1;
    ifa.mem_ready = 1'b0; ifa.opcode = 6'h00; ifa.funct = 6'h00; ifa.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.mem_req", ifa.mem_req, 0);
    chk("rst.state", ifa.state, 0);
    chk("rst.retired", ifa.retired, 0);
    chk("rst.illegal", ifa.illegal, 0);
    chk("rst.bus_err", ifa.bus_err, 0);
    do_reset;
    #1 chk("rst.fetch_req", ifa.mem_req, 1);

    do_reset;
    for (int i = 0; i < 14; i++)
      check_instr($sformatf("vec%0d", i), vec[i].k, vec[i].z, vec[i].fd, vec[i].md, vec[i].e);

    do_reset;
    for (int i = 0; i < 40; i++) begin
      int k, fd, md;
      bit z;
      k  = $urandom_range(0, 11);
      z  = 1'($urandom_range(0, 1));
      fd = $urandom_range(0, 4);
      md = $urandom_range(0, 4);
      check_instr($sformatf("rnd%0d_k%0d", i, k), k, z, fd, md, model(k, z, fd, md));
    end

    // Illegal op: dut_a halts, dut_b retires it as a NOP
    for (int t = 0; t < 2; t++) begin
      do_reset;
      @(negedge clk);
      ifa.opcode = (t == 0) ? 6'h3F : 6'h00;
      ifa.funct  = (t == 0) ? 6'h00 : 6'h21;
      ifa.mem_ready = 1'b1;
      @(negedge clk);
      ifa.mem_ready = 1'b0;
      #1;
      chk($sformatf("ill%0d.a_pc_we", t), ifa.pc_we, 0);
      chk($sformatf("ill%0d.b_pc_we", t), ifb.pc_we, 1);
      chk($sformatf("ill%0d.b_pc_sel", t), ifb.pc_sel, 0);
      @(posedge clk);
      #1;
      chk($sformatf("ill%0d.a_state", t), ifa.state, 5);
      chk($sformatf("ill%0d.a_illegal", t), ifa.illegal, 1);
      chk($sformatf("ill%0d.a_retired", t), ifa.retired, 0);
      chk($sformatf("ill%0d.b_state", t), ifb.state, 0);
      chk($sformatf("ill%0d.b_illegal", t), ifb.illegal, 1);
      chk($sformatf("ill%0d.b_retired", t), ifb.retired, 1);
      ifa.mem_ready = 1'b1;
      #1 chk($sformatf("ill%0d.halt_req", t), ifa.mem_req, 0);
    end

    // Fetch timeout after 15 idle cycles
    do_reset;
    repeat (14) @(posedge clk);
    #1;
    chk("to.bus_err_14", ifa.bus_err, 0);
    chk("to.state_14", ifa.state, 0);
    @(posedge clk);
    #1;
    chk("to.bus_err_15", ifa.bus_err, 1);
    chk("to.state_15", ifa.state, 5);
    chk("to.mem_req", ifa.mem_req, 0);
    ifa.mem_ready = 1'b1;
    #1;
    chk("to.ir_we", ifa.ir_we, 0);
    chk("to.pc_we", ifa.pc_we, 0);

    // Ready on the 15th cycle beats the timeout
    do_reset;
    repeat (14) @(posedge clk);
    #1 ifa.mem_ready = 1'b1;
    #1 chk("rw.ir_we", ifa.ir_we, 1);
    @(posedge clk);
    #1;
    chk("rw.state", ifa.state, 1);
    chk("rw.bus_err", ifa.bus_err, 0);

    // Reset during the data phase of sw
    do_reset;
    check_instr("pre_add", 0, 1'b0, 0, 0, model(0, 1'b0, 0, 0));
    @(negedge clk);
    ifa.opcode = 6'h2B; ifa.funct = 6'h00; ifa.mem_ready = 1'b1;
    @(negedge clk);
    ifa.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("swr.mem_we", ifa.mem_we, 1);
    chk("swr.mem_req", ifa.mem_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("swr.mem_we_drop", ifa.mem_we, 0);
    chk("swr.mem_req_drop", ifa.mem_req, 0);
    chk("swr.pc_we", ifa.pc_we, 0);
    chk("swr.state", ifa.state, 0);
    chk("swr.retired", ifa.retired, 0);
    do_reset;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
